// File: rtl/rtc_time_keeper.sv
// rtl/rtc_time_keeper.sv - prescaled time-of-day keeper with load, 12/24h display and day tick; alarm option: RTC_ALARM_EN
module rtc_time_keeper #(
   parameter int P_COUNT_BIT = 30,
   parameter int P_SEC_BIT   = 6,
   parameter int P_MIN_BIT   = 6,
   parameter int P_HOUR_BIT  = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_run_en,
   input  logic [P_COUNT_BIT-1:0] i_freq,
   input  logic                   i_load,
   input  logic [P_SEC_BIT-1:0]   i_load_sec,
   input  logic [P_MIN_BIT-1:0]   i_load_min,
   input  logic [P_HOUR_BIT-1:0]  i_load_hour,
   input  logic                   i_mode_12h,
   input  logic                   i_alarm_set,
   input  logic [P_MIN_BIT-1:0]   i_alarm_min,
   input  logic [P_HOUR_BIT-1:0]  i_alarm_hour,
   input  logic                   i_alarm_arm,
   output logic                   o_one_sec_tick,
   output logic [P_SEC_BIT-1:0]   o_sec,
   output logic [P_MIN_BIT-1:0]   o_minute,
   output logic [P_HOUR_BIT-1:0]  o_hour,
   output logic                   o_pm,
   output logic                   o_day_tick,
   output logic                   o_load_err,
   output logic                   o_alarm
);

   localparam logic [P_SEC_BIT-1:0]  SEC_MAX  = P_SEC_BIT'(59);
   localparam logic [P_MIN_BIT-1:0]  MIN_MAX  = P_MIN_BIT'(59);
   localparam logic [P_HOUR_BIT-1:0] HOUR_MAX = P_HOUR_BIT'(23);
   localparam logic [P_HOUR_BIT-1:0] HOUR_12  = P_HOUR_BIT'(12);

   logic [P_COUNT_BIT-1:0] cnt;
   logic [P_COUNT_BIT-1:0] cnt_last;
   logic                   tick;
   logic [P_SEC_BIT-1:0]   sec;
   logic [P_SEC_BIT-1:0]   sec_nxt;
   logic [P_MIN_BIT-1:0]   min;
   logic [P_MIN_BIT-1:0]   min_nxt;
   logic [P_HOUR_BIT-1:0]  hour;
   logic [P_HOUR_BIT-1:0]  hour_nxt;
   logic [P_HOUR_BIT-1:0]  hour_12;
   logic                   sec_wrap;
   logic                   min_wrap;
   logic                   day_wrap;
   logic                   load_ok;
   logic                   day_tick;
   logic                   load_err;
   logic                   alarm;
   logic                   alarm_bad;

   // Terminal count N-1 with N = max(i_freq, 1); ">=" lets a lowered i_freq wrap at once
   assign cnt_last = (i_freq == '0) ? '0 : i_freq - P_COUNT_BIT'(1);

   // Full-width range check so stray upper bits reject the load
   assign load_ok = i_load && (i_load_sec <= SEC_MAX) && (i_load_min <= MIN_MAX)
                    && (i_load_hour <= HOUR_MAX);

   // Prescaler: a valid load restarts the second and suppresses the tick
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (load_ok) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (i_run_en) begin
         if (cnt >= cnt_last) begin
            cnt  <= '0;
            tick <= 1'b1;
         end else begin
            cnt  <= cnt + P_COUNT_BIT'(1);
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

   // Incremented time with cascaded carries
   always_comb begin
      sec_wrap = (sec >= SEC_MAX);
      min_wrap = (min >= MIN_MAX);
      day_wrap = sec_wrap && min_wrap && (hour >= HOUR_MAX);
      sec_nxt  = sec_wrap ? '0 : sec + P_SEC_BIT'(1);
      min_nxt  = min;
      hour_nxt = hour;
      if (sec_wrap) begin
         min_nxt = min_wrap ? '0 : min + P_MIN_BIT'(1);
         if (min_wrap) begin
            hour_nxt = (hour >= HOUR_MAX) ? '0 : hour + P_HOUR_BIT'(1);
         end
      end
   end

   // Time registers: load wins over a coincident tick; day tick only from an increment
   always_ff @(posedge clk) begin
      if (reset) begin
         sec      <= '0;
         min      <= '0;
         hour     <= '0;
         day_tick <= 1'b0;
      end else begin
         day_tick <= 1'b0;
         if (load_ok) begin
            sec  <= i_load_sec;
            min  <= i_load_min;
            hour <= i_load_hour;
         end else if (tick) begin
            sec      <= sec_nxt;
            min      <= min_nxt;
            hour     <= hour_nxt;
            day_tick <= day_wrap;
         end
      end
   end

   // Rejected time load or alarm set pulses the error flag for one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         load_err <= 1'b0;
      end else begin
         load_err <= (i_load && !load_ok) || alarm_bad;
      end
   end

`ifdef RTC_ALARM_EN
   logic [P_MIN_BIT-1:0]  alarm_min;
   logic [P_HOUR_BIT-1:0] alarm_hour;
   logic                  alarm_ok;

   assign alarm_ok  = i_alarm_set && (i_alarm_min <= MIN_MAX) && (i_alarm_hour <= HOUR_MAX);
   assign alarm_bad = i_alarm_set && !alarm_ok;

   // Alarm time registers, only written by an in-range set
   always_ff @(posedge clk) begin
      if (reset) begin
         alarm_min  <= '0;
         alarm_hour <= '0;
      end else if (alarm_ok) begin
         alarm_min  <= i_alarm_min;
         alarm_hour <= i_alarm_hour;
      end
   end

   // Alarm fires when an increment lands on hh:mm:00; loads never fire it
   always_ff @(posedge clk) begin
      if (reset) begin
         alarm <= 1'b0;
      end else begin
         alarm <= tick && !load_ok && i_alarm_arm && sec_wrap
                  && (min_nxt == alarm_min) && (hour_nxt == alarm_hour);
      end
   end
`else
   logic unused_alarm;
   assign unused_alarm = ^{i_alarm_set, i_alarm_min, i_alarm_hour, i_alarm_arm};
   assign alarm_bad    = 1'b0;
   assign alarm        = 1'b0;
`endif

   // Display hour: 12-hour mode maps 0 and 12 to 12
   always_comb begin
      hour_12 = hour;
      if (hour >= HOUR_12) begin
         hour_12 = hour - HOUR_12;
      end
      if (hour_12 == '0) begin
         hour_12 = HOUR_12;
      end
      o_hour = i_mode_12h ? hour_12 : hour;
   end

   assign o_pm           = (hour >= HOUR_12);
   assign o_one_sec_tick = tick;
   assign o_sec          = sec;
   assign o_minute       = min;
   assign o_day_tick     = day_tick;
   assign o_load_err     = load_err;
   assign o_alarm        = alarm;

endmodule

// File: tb/tb_rtc_time_keeper.sv
// tb/tb_rtc_time_keeper.sv - self-checking bench for rtc_time_keeper
module tb_rtc_time_keeper;

   localparam int CB = 30;
   localparam int SB = 6;
   localparam int MB = 6;
   localparam int HB = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          run_en = 1'b0;
   logic [CB-1:0] freq = '0;
   logic          load = 1'b0;
   logic [SB-1:0] load_sec = '0;
   logic [MB-1:0] load_min = '0;
   logic [HB-1:0] load_hour = '0;
   logic          mode_12h = 1'b0;
   logic          alarm_set = 1'b0;
   logic [MB-1:0] alarm_min = '0;
   logic [HB-1:0] alarm_hour = '0;
   logic          alarm_arm = 1'b0;
   logic          one_sec_tick;
   logic [SB-1:0] sec;
   logic [MB-1:0] minute;
   logic [HB-1:0] hour;
   logic          pm;
   logic          day_tick;
   logic          load_err;
   logic          alarm;

   always #5 clk = ~clk;

   rtc_time_keeper #(.P_COUNT_BIT(CB), .P_SEC_BIT(SB), .P_MIN_BIT(MB), .P_HOUR_BIT(HB)) dut (
      .clk(clk), .reset(reset), .i_run_en(run_en), .i_freq(freq), .i_load(load),
      .i_load_sec(load_sec), .i_load_min(load_min), .i_load_hour(load_hour),
      .i_mode_12h(mode_12h), .i_alarm_set(alarm_set), .i_alarm_min(alarm_min),
      .i_alarm_hour(alarm_hour), .i_alarm_arm(alarm_arm), .o_one_sec_tick(one_sec_tick),
      .o_sec(sec), .o_minute(minute), .o_hour(hour), .o_pm(pm), .o_day_tick(day_tick),
      .o_load_err(load_err), .o_alarm(alarm)
   );

   typedef struct {
      logic tick;
      logic day;
      logic err;
      logic alm;
      int   tod;
   } exp_t;

   typedef struct {
      logic [SB-1:0] s;
      logic [MB-1:0] m;
      logic [HB-1:0] h;
      logic          mode;
      logic          err;
      logic [HB-1:0] hd;
      logic          pm;
   } vec_t;

   exp_t sb_q[$];
   vec_t vt[9];
   int   n_checks = 0;
   int   n_fail = 0;
   int   m_cnt = 0;
   bit   m_tick = 1'b0;
   int   m_tod = 0;
   int   m_al_tod = 0;
   int   cnt_a;
   int   first;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model on seconds-of-day; pushes the expected post-edge outputs
   task automatic model_push();
      exp_t e;
      int   n;
      bit   lv;
      e.tick = 1'b0; e.day = 1'b0; e.err = 1'b0; e.alm = 1'b0;
      n = (freq == 0) ? 1 : int'(freq);
      if (reset) begin
         m_cnt = 0; m_tod = 0; m_al_tod = 0;
      end else begin
         lv = load && (load_sec < 60) && (load_min < 60) && (load_hour < 24);
         if (load && !lv) e.err = 1'b1;
`ifdef RTC_ALARM_EN
         if (alarm_set && (alarm_min < 60) && (alarm_hour < 24))
            m_al_tod = int'(alarm_hour) * 3600 + int'(alarm_min) * 60;
         else if (alarm_set)
            e.err = 1'b1;
`endif
         if (lv) begin
            m_tod = int'(load_hour) * 3600 + int'(load_min) * 60 + int'(load_sec);
            m_cnt = 0;
         end else begin
            if (m_tick) begin
               m_tod = (m_tod + 1) % 86400;
               e.day = (m_tod == 0);
`ifdef RTC_ALARM_EN
               e.alm = alarm_arm && (m_tod == m_al_tod);
`endif
            end
            if (run_en) begin
               if (m_cnt >= n - 1) begin
                  m_cnt = 0; e.tick = 1'b1;
               end else begin
                  m_cnt++;
               end
            end
         end
      end
      m_tick = e.tick;
      e.tod = m_tod;
      sb_q.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      int   h;
      int   hd;
      model_push();
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      h = e.tod / 3600;
      hd = mode_12h ? (((h % 12) == 0) ? 12 : h % 12) : h;
      chk("tick", 32'(one_sec_tick), 32'(e.tick));
      chk("sec", 32'(sec), 32'(e.tod % 60));
      chk("min", 32'(minute), 32'((e.tod / 60) % 60));
      chk("hour", 32'(hour), 32'(hd));
      chk("pm", 32'(pm), 32'(h >= 12));
      chk("day_tick", 32'(day_tick), 32'(e.day));
      chk("load_err", 32'(load_err), 32'(e.err));
      chk("alarm", 32'(alarm), 32'(e.alm));
   endtask

   task automatic do_load(input int h, input int m, input int s);
      load = 1'b1; load_hour = HB'(h); load_min = MB'(m); load_sec = SB'(s);
      step();
      load = 1'b0;
   endtask

   initial begin
      vt[0] = '{6'd30, 6'd20, 5'd10, 1'b0, 1'b0, 5'd10, 1'b0};
      vt[1] = '{6'd0,  6'd60, 5'd5,  1'b0, 1'b1, 5'd10, 1'b0};
      vt[2] = '{6'd0,  6'd0,  5'd12, 1'b1, 1'b0, 5'd12, 1'b1};
      vt[3] = '{6'd0,  6'd30, 5'd0,  1'b1, 1'b0, 5'd12, 1'b0};
      vt[4] = '{6'd0,  6'd0,  5'd13, 1'b1, 1'b0, 5'd1,  1'b1};
      vt[5] = '{6'd0,  6'd0,  5'd24, 1'b0, 1'b1, 5'd13, 1'b1};
      vt[6] = '{6'd59, 6'd59, 5'd23, 1'b1, 1'b0, 5'd11, 1'b1};
      vt[7] = '{6'd60, 6'd0,  5'd0,  1'b1, 1'b1, 5'd11, 1'b1};
      vt[8] = '{6'd0,  6'd0,  5'd23, 1'b0, 1'b0, 5'd23, 1'b1};

      // Reset state, 12-hour display shows 12
      mode_12h = 1'b1;
      step(); step();
      chk("rst_hour12", 32'(hour), 32'd12);
      chk("rst_pm", 32'(pm), 32'd0);
      mode_12h = 1'b0;

      // Tick every 4th cycle, then every cycle with i_freq = 0
      reset = 1'b0; run_en = 1'b1; freq = CB'(4);
      cnt_a = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (one_sec_tick) cnt_a++;
      end
      chk("ticks_f4", 32'(cnt_a), 32'd4);
      chk("sec_f4", 32'(sec), 32'd3);
      freq = '0; cnt_a = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (one_sec_tick) cnt_a++;
      end
      chk("ticks_f0", 32'(cnt_a), 32'd8);

      // Day rollover from 23:59:58
      freq = CB'(2);
      do_load(23, 59, 58);
      chk("pm_before", 32'(pm), 32'd1);
      cnt_a = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (day_tick) cnt_a++;
      end
      chk("day_ticks", 32'(cnt_a), 32'd1);
      chk("pm_after", 32'(pm), 32'd0);

      // Table of loads and display modes with the prescaler stopped
      run_en = 1'b0;
      step();
      for (int i = 0; i < 9; i++) begin
         mode_12h = vt[i].mode;
         do_load(int'(vt[i].h), int'(vt[i].m), int'(vt[i].s));
         chk("vec_err", 32'(load_err), 32'(vt[i].err));
         chk("vec_hour", 32'(hour), 32'(vt[i].hd));
         chk("vec_pm", 32'(pm), 32'(vt[i].pm));
         step();
         chk("vec_err_clr", 32'(load_err), 32'd0);
      end
      mode_12h = 1'b0;

      // Load coinciding with the prescaler wrap
      run_en = 1'b1; freq = CB'(4);
      do_load(2, 0, 0);
      step(); step(); step();
      do_load(5, 6, 7);
      chk("wrap_tick", 32'(one_sec_tick), 32'd0);
      chk("wrap_sec", 32'(sec), 32'd7);
      first = 0;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (one_sec_tick && first == 0) first = i;
      end
      chk("wrap_next_tick", 32'(first), 32'd4);

      // Run enable gap at counter = 2
      freq = CB'(5);
      do_load(1, 0, 0);
      step(); step();
      run_en = 1'b0; cnt_a = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (one_sec_tick) cnt_a++;
      end
      chk("gap_ticks", 32'(cnt_a), 32'd0);
      run_en = 1'b1; first = 0;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (one_sec_tick && first == 0) first = i;
      end
      chk("gap_resume", 32'(first), 32'd3);

`ifdef RTC_ALARM_EN
      // Alarm at 07:30, armed then disarmed
      alarm_set = 1'b1; alarm_hour = HB'(7); alarm_min = MB'(30);
      step();
      alarm_set = 1'b0; alarm_arm = 1'b1; freq = CB'(1);
      do_load(7, 29, 59);
      cnt_a = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (alarm) cnt_a++;
      end
      chk("alarm_armed", 32'(cnt_a), 32'd1);
      alarm_arm = 1'b0;
      do_load(7, 29, 59);
      cnt_a = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (alarm) cnt_a++;
      end
      chk("alarm_disarmed", 32'(cnt_a), 32'd0);
`endif

      // Reset mid-second wins
      freq = CB'(7);
      step(); step();
      reset = 1'b1; load = 1'b1; load_hour = HB'(3);
      step();
      load = 1'b0;
      chk("rst_mid_sec", 32'(sec), 32'd0);
      chk("rst_mid_hour", 32'(hour), 32'd0);
      reset = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
